// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by the CPU blocks.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/mem_arbiter_types_pkg.sv
// Types and defaults for the shared-RAM arbiter.
package mem_arbiter_types_pkg;

  typedef enum logic [1:0] {IDLE, DSERV, ISERV} arb_state_t;
  typedef enum logic {OP_READ, OP_WRITE} mem_op_t;

  localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's requester and RAM-side signals.
interface mem_arbiter_if;

  logic                 CLK;
  logic                 RST;
  logic                 iREN;
  cpu_types_pkg::word_t iaddr;
  logic                 ihit;
  cpu_types_pkg::word_t iload;
  logic                 dREN;
  logic                 dWEN;
  cpu_types_pkg::word_t daddr;
  cpu_types_pkg::word_t dstore;
  logic                 dhit;
  cpu_types_pkg::word_t dload;
  logic                 ram_ren;
  logic                 ram_wen;
  cpu_types_pkg::word_t ram_addr;
  cpu_types_pkg::word_t ram_store;
  cpu_types_pkg::word_t ram_load;
  logic                 ram_ready;
  logic                 busy;

  modport arb (
    input  CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    output ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_store, busy
  );

  modport tb (
    output CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    input  ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_store, busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data accesses.
// Data wins by default; a starvation counter forces a fetch after STARVE_MAX data grants.
module mem_arbiter
  import mem_arbiter_types_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  arb_state_t        state_q, state_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  mem_op_t           op_q, op_d;
  logic              d_req;
  logic              starve_ok;
  logic              active;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      op_q     <= OP_READ;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      op_q     <= op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    store_d   = store_q;
    op_d      = op_q;
    d_req     = dREN | dWEN;
    starve_ok = starve_q < CntW'(STARVE_MAX);
    unique case (state_q)
      IDLE: begin
        if (d_req && (!iREN || starve_ok)) begin
          state_d = DSERV;
          addr_d  = daddr;
          store_d = dstore;
          op_d    = dWEN ? OP_WRITE : OP_READ;
          // Count only data grants that made a waiting fetch wait longer.
          if (!iREN) begin
            starve_d = '0;
          end else if (starve_ok) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (iREN) begin
          state_d  = ISERV;
          addr_d   = iaddr;
          store_d  = '0;
          op_d     = OP_READ;
          starve_d = '0;
        end
      end
      DSERV, ISERV: begin
        if (ram_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM side is driven only from latched state so requester churn cannot disturb an access.
  always_comb begin
    active    = state_q != IDLE;
    busy      = active;
    ihit      = (state_q == ISERV) && ram_ready;
    dhit      = (state_q == DSERV) && ram_ready;
    ram_ren   = (state_q == ISERV) || ((state_q == DSERV) && (op_q == OP_READ));
    ram_wen   = (state_q == DSERV) && (op_q == OP_WRITE);
    ram_addr  = active ? addr_q : '0;
    ram_store = (state_q == DSERV) ? store_q : '0;
    iload     = ihit ? ram_load : '0;
    dload     = (dhit && (op_q == OP_READ)) ? ram_load : '0;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-fetch requester and the data requester.
- The data requester is the one driven by the decoder's dRENi/dWENi (LW/SW).
- Sits between the datapath/request logic and the RAM model.
- Returns ihit/dhit, which gate RegWEN and PC advance in the control path.
- Data normally has priority; a starvation counter guarantees forward progress for instruction fetch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width.
- STARVE_MAX, 4, consecutive data grants tolerated while a fetch is pending (must be >= 1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- iREN  in  1  instruction read request (level).
- iaddr  in  ADDR_W  fetch address.
- ihit  out  1  fetch complete; iload valid this cycle.
- iload  out  DATA_W  fetched word.
- dREN  in  1  data read request (level).
- dWEN  in  1  data write request (level).
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dhit  out  1  data access complete; dload valid on reads.
- dload  out  DATA_W  loaded word.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_store  out  DATA_W  RAM write data.
- ram_load  in  DATA_W  RAM read data; valid when ram_ready.
- ram_ready  in  1  RAM completes the current access this cycle.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, starve_cnt=0, latched address/data/op registers = 0.
  - ihit=dhit=ram_ren=ram_wen=busy=0.
  - iload=dload=ram_addr=ram_store=0.
- States: IDLE, DSERV, ISERV.
- Arbitration in IDLE, evaluated each cycle:
  - d_req = dREN|dWEN. If both dREN and dWEN are set, treat as a write.
  - If d_req and (!iREN or starve_cnt<STARVE_MAX): go to DSERV. Latch daddr, dstore and op.
    - starve_cnt increments (saturating at STARVE_MAX) if iREN is high, else clears.
  - Else if iREN: go to ISERV, latch iaddr, clear starve_cnt.
  - Else stay in IDLE.
- DSERV / ISERV:
  - Drive ram_ren/ram_wen, ram_addr and ram_store from the latched registers, not from the live inputs.
  - Hold all of them stable until ram_ready.
  - In ISERV, ram_wen=0 and ram_store=0.
- Completion:
  - On the cycle ram_ready=1, assert the matching hit for exactly one cycle (combinational from ram_ready & state).
  - Drive iload/dload = ram_load that same cycle; they are 0 otherwise. dload=0 on write completion.
  - Next state is IDLE.
- Latency:
  - Request seen at cycle 0 leads to a RAM strobe from cycle 1.
  - Hit arrives at cycle 1+L, where L is RAM cycles to ram_ready (L>=0 relative to strobe; ram_ready may be high in the first strobe cycle).
  - Minimum request-to-hit time is 1 cycle. At least one IDLE cycle separates consecutive accesses.
- ram_ready while in IDLE is ignored; no hit is produced.
- A request dropped mid-access does not abort the access: the RAM access completes and the hit still pulses. Requesters ignore unsolicited hits.
- A request held high after its hit is treated as a new access at the next IDLE arbitration.
- Input changes during a grant do not affect the RAM signals.
- RST asserted mid-access aborts immediately to reset values. No hit is emitted.
- Starvation: with iREN held continuously and data requests back-to-back, at most STARVE_MAX data accesses occur before a fetch is granted.

Decomposition:
- Shared package mem_arbiter_types_pkg holds:
  - typedef enum logic [1:0] {IDLE, DSERV, ISERV} arb_state_t;
  - typedef enum logic {OP_READ, OP_WRITE} mem_op_t;
  - a default STARVE_MAX constant.
- Width types reuse word_t from cpu_types_pkg.
- Interface mem_arbiter_if carries the ports, with modports for the arbiter and the test bench.
- No sub-module is needed. The starvation counter is small enough to stay inline.

Test Plan:
- Reset mid-access: RST pulsed during DSERV -> outputs at reset values immediately; starve_cnt=0; no hit on release.
- Lone fetch: iREN=1, iaddr=0x40, RAM L=2 returning 0x8C220004 -> ram_ren=1 with ram_addr=0x40 from cycle 1; ihit=1 and iload=0x8C220004 at cycle 3 only; dhit stays 0.
- Store: dWEN=1, daddr=0x100, dstore=0xDEADBEEF, with daddr changed to 0x200 in cycle 2 -> ram_wen=1, ram_addr=0x100, ram_store=0xDEADBEEF held until ram_ready; dhit one cycle; dload=0.
- Simultaneous requests: iREN=dREN=1 in the same cycle -> DSERV first, then one IDLE cycle, then ISERV.
- Starvation: iREN held, dREN held for 10 accesses, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Zero-latency RAM: ram_ready tied high -> hit 1 cycle after request, then one busy=0 cycle; a held iREN yields an ihit every 2 cycles.
